// File: rtl/boundary_exchange_pkg.sv
// Shared simulation package: coordinate width default and the FSM state
// encoding for the boundary exchange between neighbouring cores.
package boundary_exchange_pkg;

    // Default coordinate width, shared with node/constraint logic.
    localparam int unsigned DATA_W_DEFAULT = 32;

    // Exchange FSM encoding.
    typedef enum logic [1:0] {
        WAIT_BOTH = 2'b00,
        HAVE_L    = 2'b01,
        HAVE_R    = 2'b10,
        COMMIT    = 2'b11
    } bx_state_e;

    // A side may hand over its position whenever it is not already staged.
    function automatic logic left_open(input bx_state_e s);
        return (s == WAIT_BOTH) || (s == HAVE_R);
    endfunction

    function automatic logic right_open(input bx_state_e s);
        return (s == WAIT_BOTH) || (s == HAVE_L);
    endfunction

endpackage : boundary_exchange_pkg

// File: rtl/stall_timer.sv
// Saturating wait counter with a sticky expiry flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   run_i      : count one cycle (holds at TIMEOUT)
//   clear_i    : zero the counter and drop the flag (wins over run_i)
//   expired_o  : registered, set on the edge the count reaches TIMEOUT
module stall_timer #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    // Next count and flag.
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (clear_i) begin
            cnt_d     = '0;
            expired_d = 1'b0;
        end else if (run_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == LIMIT) begin
                expired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule : stall_timer

// File: rtl/boundary_exchange.sv
// Boundary exchange between two adjacent simulation cores. Collects the left
// core's last node and the right core's first node over independent
// valid/ready handshakes and commits them together as one snapshot.
//   clk, reset           : clock, asynchronous active-low reset
//   l_valid/l_ready/l_x/l_y : left core's last node position
//   r_valid/r_ready/r_x/r_y : right core's first node position
//   prev_core_last_x/y   : committed left position (to the right core)
//   next_core_first_x/y  : committed right position (to the left core)
//   publish              : one-cycle pulse when a new snapshot appears
//   step_count           : commits since reset, wrapping
//   stall                : sticky timeout while one side waits; cleared by commit
module boundary_exchange
    import boundary_exchange_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned STEP_W  = 16,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [DATA_W-1:0] l_x,
    input  logic [DATA_W-1:0] l_y,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_x,
    input  logic [DATA_W-1:0] r_y,
    output logic [DATA_W-1:0] prev_core_last_x,
    output logic [DATA_W-1:0] prev_core_last_y,
    output logic [DATA_W-1:0] next_core_first_x,
    output logic [DATA_W-1:0] next_core_first_y,
    output logic              publish,
    output logic [STEP_W-1:0] step_count,
    output logic              stall
);

    bx_state_e         state_q;
    logic [DATA_W-1:0] l_x_stage_q, l_y_stage_q;
    logic [DATA_W-1:0] r_x_stage_q, r_y_stage_q;
    logic [DATA_W-1:0] prev_x_q, prev_y_q, next_x_q, next_y_q;
    logic [STEP_W-1:0] step_q;
    logic              publish_q;

    logic l_hs_c, r_hs_c, commit_c, waiting_c;

    // Readies decode straight from the state register.
    assign l_ready = left_open(state_q);
    assign r_ready = right_open(state_q);

    // Handshakes and the edge that completes a pair.
    always_comb begin
        l_hs_c    = l_valid && l_ready;
        r_hs_c    = r_valid && r_ready;
        waiting_c = (state_q == HAVE_L) || (state_q == HAVE_R);
        commit_c  = 1'b0;
        case (state_q)
            WAIT_BOTH: commit_c = l_hs_c && r_hs_c;
            HAVE_L:    commit_c = r_hs_c;
            HAVE_R:    commit_c = l_hs_c;
            default:   commit_c = 1'b0;
        endcase
    end

    // FSM, staging and snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_BOTH;
            l_x_stage_q <= '0;
            l_y_stage_q <= '0;
            r_x_stage_q <= '0;
            r_y_stage_q <= '0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            next_x_q    <= '0;
            next_y_q    <= '0;
            step_q      <= '0;
            publish_q   <= 1'b0;
        end else begin
            publish_q <= commit_c;

            if (l_hs_c) begin
                l_x_stage_q <= l_x;
                l_y_stage_q <= l_y;
            end
            if (r_hs_c) begin
                r_x_stage_q <= r_x;
                r_y_stage_q <= r_y;
            end

            // The side completing on the commit edge bypasses its staging.
            if (commit_c) begin
                prev_x_q <= l_hs_c ? l_x : l_x_stage_q;
                prev_y_q <= l_hs_c ? l_y : l_y_stage_q;
                next_x_q <= r_hs_c ? r_x : r_x_stage_q;
                next_y_q <= r_hs_c ? r_y : r_y_stage_q;
                step_q   <= step_q + STEP_W'(1);
            end

            case (state_q)
                WAIT_BOTH: begin
                    if (commit_c)    state_q <= COMMIT;
                    else if (l_hs_c) state_q <= HAVE_L;
                    else if (r_hs_c) state_q <= HAVE_R;
                end
                HAVE_L:  if (commit_c) state_q <= COMMIT;
                HAVE_R:  if (commit_c) state_q <= COMMIT;
                default: state_q <= WAIT_BOTH;
            endcase
        end
    end

    stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clk       (clk),
        .rst_n     (reset),
        .run_i     (waiting_c),
        .clear_i   (commit_c),
        .expired_o (stall)
    );

    assign prev_core_last_x  = prev_x_q;
    assign prev_core_last_y  = prev_y_q;
    assign next_core_first_x = next_x_q;
    assign next_core_first_y = next_y_q;
    assign step_count        = step_q;
    assign publish           = publish_q;

endmodule : boundary_exchange

// File: tb/tb_boundary_exchange.sv
module tb_boundary_exchange;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STEP_W  = 2;
    localparam int unsigned TIMEOUT = 8;

    typedef struct {
        logic [DATA_W-1:0] lx, ly, rx, ry;
        logic [STEP_W-1:0] step;
    } exp_t;

    logic              clk, reset;
    logic              l_valid, l_ready, r_valid, r_ready;
    logic [DATA_W-1:0] l_x, l_y, r_x, r_y;
    logic [DATA_W-1:0] pl_x, pl_y, nf_x, nf_y;
    logic              publish, stall;
    logic [STEP_W-1:0] step_count;

    exp_t              sb[$];
    logic [STEP_W-1:0] exp_step;
    int                n_cmp, n_fail;

    boundary_exchange #(
        .DATA_W (DATA_W),
        .STEP_W (STEP_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .l_valid          (l_valid),
        .l_ready          (l_ready),
        .l_x              (l_x),
        .l_y              (l_y),
        .r_valid          (r_valid),
        .r_ready          (r_ready),
        .r_x              (r_x),
        .r_y              (r_y),
        .prev_core_last_x (pl_x),
        .prev_core_last_y (pl_y),
        .next_core_first_x(nf_x),
        .next_core_first_y(nf_y),
        .publish          (publish),
        .step_count       (step_count),
        .stall            (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue an expected snapshot for the commit the next edge completes.
    task automatic expect_commit(input logic [DATA_W-1:0] lx, ly, rx, ry);
        exp_t e;
        exp_step = exp_step + STEP_W'(1);
        e.lx = lx; e.ly = ly; e.rx = rx; e.ry = ry; e.step = exp_step;
        sb.push_back(e);
    endtask

    // Advance one edge, sample 1 time unit later, score any published snapshot.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (publish === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_publish", 64'(publish), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("prev_core_last_x", 64'(pl_x), 64'(e.lx));
                chk("prev_core_last_y", 64'(pl_y), 64'(e.ly));
                chk("next_core_first_x", 64'(nf_x), 64'(e.rx));
                chk("next_core_first_y", 64'(nf_y), 64'(e.ry));
                chk("step_count", 64'(step_count), 64'(e.step));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pl_x"}, 64'(pl_x), 64'(0));
        chk({tag, "_pl_y"}, 64'(pl_y), 64'(0));
        chk({tag, "_nf_x"}, 64'(nf_x), 64'(0));
        chk({tag, "_nf_y"}, 64'(nf_y), 64'(0));
        chk({tag, "_step"}, 64'(step_count), 64'(0));
        chk({tag, "_publish"}, 64'(publish), 64'(0));
        chk({tag, "_stall"}, 64'(stall), 64'(0));
        chk({tag, "_l_ready"}, 64'(l_ready), 64'(1));
        chk({tag, "_r_ready"}, 64'(r_ready), 64'(1));
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; exp_step = '0;
        reset = 1'b0;
        l_valid = 1'b0; r_valid = 1'b0;
        l_x = '0; l_y = '0; r_x = '0; r_y = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            l_valid = 1'($urandom); r_valid = 1'($urandom);
            l_x = $urandom; l_y = $urandom; r_x = $urandom; r_y = $urandom;
            @(posedge clk);
            #1;
        end
        chk_reset_outputs("reset");
        l_valid = 1'b0; r_valid = 1'b0;
        reset = 1'b1;
        tick();

        // Simultaneous post.
        l_valid = 1'b1; l_x = 32'h10; l_y = 32'h20;
        r_valid = 1'b1; r_x = 32'h30; r_y = 32'h40;
        expect_commit(32'h10, 32'h20, 32'h30, 32'h40);
        tick();
        l_valid = 1'b0; r_valid = 1'b0;
        chk("simul_publish", 64'(publish), 64'(1));
        chk("simul_l_ready_commit", 64'(l_ready), 64'(0));
        chk("simul_r_ready_commit", 64'(r_ready), 64'(0));
        tick();
        chk("simul_l_ready_after", 64'(l_ready), 64'(1));
        chk("simul_r_ready_after", 64'(r_ready), 64'(1));
        chk("simul_publish_after", 64'(publish), 64'(0));

        // Skew and backpressure.
        l_valid = 1'b1; l_x = 32'hA; l_y = 32'hB;
        tick();
        l_x = 32'hC; l_y = 32'hD;
        for (int i = 0; i < 4; i++) begin
            chk("skew_l_ready_held", 64'(l_ready), 64'(0));
            chk("skew_r_ready_open", 64'(r_ready), 64'(1));
            chk("skew_no_publish", 64'(publish), 64'(0));
            tick();
        end
        chk("skew_l_ready_edge", 64'(l_ready), 64'(0));
        r_valid = 1'b1; r_x = 32'h1; r_y = 32'h2;
        expect_commit(32'hA, 32'hB, 32'h1, 32'h2);
        tick();
        r_valid = 1'b0;
        chk("skew_publish", 64'(publish), 64'(1));
        chk("skew_l_ready_commit", 64'(l_ready), 64'(0));
        tick();
        chk("skew_l_ready_reopen", 64'(l_ready), 64'(1));
        tick();
        l_valid = 1'b0;
        chk("skew_second_have_l", 64'(l_ready), 64'(0));
        r_valid = 1'b1; r_x = 32'h5; r_y = 32'h6;
        expect_commit(32'hC, 32'hD, 32'h5, 32'h6);
        tick();
        r_valid = 1'b0;
        tick();

        // Timeout with only the right side posted.
        r_valid = 1'b1; r_x = 32'h7; r_y = 32'h8;
        tick();
        r_valid = 1'b0;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            chk("timeout_stall_low", 64'(stall), 64'(0));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("timeout_stall_high", 64'(stall), 64'(1));
            chk("timeout_r_ready", 64'(r_ready), 64'(0));
            tick();
        end
        l_valid = 1'b1; l_x = 32'h9; l_y = 32'h10A;
        expect_commit(32'h9, 32'h10A, 32'h7, 32'h8);
        tick();
        l_valid = 1'b0;
        chk("timeout_publish", 64'(publish), 64'(1));
        chk("timeout_stall_cleared", 64'(stall), 64'(0));
        tick();

        // Reset in the middle of a step.
        l_valid = 1'b1; l_x = 32'h55; l_y = 32'h66;
        tick();
        l_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_step = '0;
        r_valid = 1'b1; r_x = 32'h77; r_y = 32'h88;
        tick();
        r_valid = 1'b0;
        chk("midreset_have_r_l_ready", 64'(l_ready), 64'(1));
        chk("midreset_have_r_r_ready", 64'(r_ready), 64'(0));
        tick();
        tick();
        chk("midreset_no_publish", 64'(publish), 64'(0));
        chk("midreset_outputs_zero", 64'(pl_x | nf_x), 64'(0));
        chk("midreset_step_zero", 64'(step_count), 64'(0));

        // Five commits to exercise step_count wrap (reads 1,2,3,0,1).
        l_valid = 1'b1; l_x = 32'h1234; l_y = 32'h5678;
        expect_commit(32'h1234, 32'h5678, 32'h77, 32'h88);
        tick();
        l_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            l_valid = 1'b1; l_x = $urandom; l_y = $urandom;
            r_valid = 1'b1; r_x = $urandom; r_y = $urandom;
            expect_commit(l_x, l_y, r_x, r_y);
            tick();
            l_valid = 1'b0; r_valid = 1'b0;
            chk("wrap_publish", 64'(publish), 64'(1));
            tick();
        end
        chk("wrap_final_step", 64'(step_count), 64'(1));
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_boundary_exchange
